ft60x_axi_ram_slave: RTL and testbench

AXI4 slave (responder) terminating the master-side AXI4 bus driven by the FT60x bridge or its retime stage. Services single and burst reads/writes into a local word-addressed RAM with byte strobes. Used as a loop-back and bring-up target for the USB-to-AXI path. The write channel (AW/W/B) and read channel (AR/R) run independently and concurrently.

---
 rtl/ft60x_axi_ram_slave.sv | 127 ++++++++++++
 tb/tb_ft60x_axi_ram_slave.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ft60x_axi_ram_slave.sv
// ft60x_axi_ram_slave: AXI4 responder over a byte-strobed word RAM, independent write and read channels
module ft60x_axi_ram_slave #(
  parameter int ADDR_W = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inport_awvalid_i,
  output logic        inport_awready_o,
  input  logic [31:0] inport_awaddr_i,
  input  logic [3:0]  inport_awid_i,
  input  logic [7:0]  inport_awlen_i,
  input  logic [1:0]  inport_awburst_i,
  input  logic        inport_wvalid_i,
  output logic        inport_wready_o,
  input  logic [31:0] inport_wdata_i,
  input  logic [3:0]  inport_wstrb_i,
  input  logic        inport_wlast_i,
  output logic        inport_bvalid_o,
  input  logic        inport_bready_i,
  output logic [1:0]  inport_bresp_o,
  output logic [3:0]  inport_bid_o,
  input  logic        inport_arvalid_i,
  output logic        inport_arready_o,
  input  logic [31:0] inport_araddr_i,
  input  logic [3:0]  inport_arid_i,
  input  logic [7:0]  inport_arlen_i,
  input  logic [1:0]  inport_arburst_i,
  output logic        inport_rvalid_o,
  input  logic        inport_rready_i,
  output logic [31:0] inport_rdata_o,
  output logic [1:0]  inport_rresp_o,
  output logic [3:0]  inport_rid_o,
  output logic        inport_rlast_o
);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_READ, R_DATA} r_state_t;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic [31:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] w_addr, r_addr;
  logic [3:0] w_id, r_id;
  logic [7:0] w_len, w_cnt, r_len, r_cnt;
  logic [1:0] w_burst, r_burst;
  logic w_err, w_beat, w_last_beat, r_beat;
  logic [31:0] r_data;
  logic unused;
  assign unused = ^{inport_awaddr_i[31:ADDR_W+2], inport_awaddr_i[1:0],
                    inport_araddr_i[31:ADDR_W+2], inport_araddr_i[1:0]};
  always_comb begin
    inport_awready_o = w_state == W_IDLE;
    inport_wready_o = w_state == W_DATA;
    inport_bvalid_o = w_state == W_RESP;
    inport_bresp_o = {w_err, 1'b0};
    inport_bid_o = w_id;
    w_beat = inport_wready_o && inport_wvalid_i;
    w_last_beat = w_beat && (w_cnt == w_len);
    w_next = (inport_awready_o && inport_awvalid_i) ? W_DATA :
             w_last_beat ? W_RESP :
             (inport_bvalid_o && inport_bready_i) ? W_IDLE : w_state;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state <= W_IDLE;
      w_addr <= '0;
      w_id <= '0;
      w_len <= '0;
      w_burst <= '0;
      w_cnt <= '0;
      w_err <= 1'b0;
    end else begin
      w_state <= w_next;
      if (inport_awready_o && inport_awvalid_i) begin
        w_addr <= inport_awaddr_i[ADDR_W+1:2];
        w_id <= inport_awid_i;
        w_len <= inport_awlen_i;
        w_burst <= inport_awburst_i;
        w_cnt <= '0;
        w_err <= inport_awburst_i[1];
      end else if (w_beat) begin
        w_addr <= (w_burst == 2'b00) ? w_addr : w_addr + 1'b1;
        w_cnt <= w_last_beat ? w_cnt : w_cnt + 1'b1;
        if (inport_wlast_i != (w_cnt == w_len)) w_err <= 1'b1;
      end
    end
  end
  // Write is suppressed during reset so an abandoned burst never lands a stray beat
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++)
      if (w_beat && !rst_i && inport_wstrb_i[i]) mem[w_addr][8*i +: 8] <= inport_wdata_i[8*i +: 8];
  end
  always_comb begin
    inport_arready_o = r_state == R_IDLE;
    inport_rvalid_o = r_state == R_DATA;
    inport_rlast_o = inport_rvalid_o && (r_cnt == r_len);
    inport_rdata_o = r_data;
    inport_rid_o = r_id;
    inport_rresp_o = {r_burst[1], 1'b0};
    r_beat = inport_rvalid_o && inport_rready_i;
    r_next = (inport_arready_o && inport_arvalid_i) ? R_READ :
             (r_state == R_READ) ? R_DATA :
             r_beat ? (inport_rlast_o ? R_IDLE : R_READ) : r_state;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= R_IDLE;
      r_addr <= '0;
      r_id <= '0;
      r_len <= '0;
      r_burst <= '0;
      r_cnt <= '0;
      r_data <= '0;
    end else begin
      r_state <= r_next;
      if (r_state == R_READ) r_data <= mem[r_addr];
      if (inport_arready_o && inport_arvalid_i) begin
        r_addr <= inport_araddr_i[ADDR_W+1:2];
        r_id <= inport_arid_i;
        r_len <= inport_arlen_i;
        r_burst <= inport_arburst_i;
        r_cnt <= '0;
      end else if (r_beat && !inport_rlast_o) begin
        r_addr <= (r_burst == 2'b00) ? r_addr : r_addr + 1'b1;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ft60x_axi_ram_slave.sv
// tb_ft60x_axi_ram_slave: directed checks of write/read bursts, strobes, errors, backpressure and reset
module tb_ft60x_axi_ram_slave;
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic awvalid = 0, awready, wvalid = 0, wready, wlast = 0, bvalid, bready = 0;
  logic arvalid = 0, arready, rvalid, rready = 0, rlast;
  logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata;
  logic [3:0] awid = 0, wstrb = 0, bid, arid = 0, rid;
  logic [7:0] awlen = 0, arlen = 0;
  logic [1:0] awburst = 0, arburst = 0, bresp, rresp;
  int checks = 0, errors = 0;
  always #5 clk_i = ~clk_i;
  ft60x_axi_ram_slave #(.ADDR_W(10)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .inport_awvalid_i(awvalid), .inport_awready_o(awready), .inport_awaddr_i(awaddr),
    .inport_awid_i(awid), .inport_awlen_i(awlen), .inport_awburst_i(awburst),
    .inport_wvalid_i(wvalid), .inport_wready_o(wready), .inport_wdata_i(wdata),
    .inport_wstrb_i(wstrb), .inport_wlast_i(wlast),
    .inport_bvalid_o(bvalid), .inport_bready_i(bready), .inport_bresp_o(bresp), .inport_bid_o(bid),
    .inport_arvalid_i(arvalid), .inport_arready_o(arready), .inport_araddr_i(araddr),
    .inport_arid_i(arid), .inport_arlen_i(arlen), .inport_arburst_i(arburst),
    .inport_rvalid_o(rvalid), .inport_rready_i(rready), .inport_rdata_o(rdata),
    .inport_rresp_o(rresp), .inport_rid_o(rid), .inport_rlast_o(rlast)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic aw_send(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len, input logic [1:0] b);
    awaddr = a; awid = id; awlen = len; awburst = b; awvalid = 1'b1;
    for (int n = 0; n < 20 && !awready; n++) @(negedge clk_i);
    check("awready", awready, 1);
    @(negedge clk_i);
    awvalid = 1'b0;
  endtask
  task automatic w_send(input logic [31:0] d, input logic [3:0] s, input logic l);
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    for (int n = 0; n < 20 && !wready; n++) @(negedge clk_i);
    check("wready", wready, 1);
    @(negedge clk_i);
    wvalid = 1'b0; wlast = 1'b0;
  endtask
  task automatic b_recv(input logic [1:0] resp, input logic [3:0] id);
    bready = 1'b1;
    for (int n = 0; n < 20 && !bvalid; n++) @(negedge clk_i);
    check("bvalid", bvalid, 1);
    check("bresp", bresp, resp);
    check("bid", bid, id);
    @(negedge clk_i);
    bready = 1'b0;
  endtask
  task automatic ar_send(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len, input logic [1:0] b);
    araddr = a; arid = id; arlen = len; arburst = b; arvalid = 1'b1;
    for (int n = 0; n < 20 && !arready; n++) @(negedge clk_i);
    check("arready", arready, 1);
    @(negedge clk_i);
    arvalid = 1'b0;
  endtask
  task automatic r_recv(input logic [31:0] d, input logic l, input logic [3:0] id, input logic [1:0] resp);
    rready = 1'b1;
    for (int n = 0; n < 20 && !rvalid; n++) @(negedge clk_i);
    check("rvalid", rvalid, 1);
    check("rdata", rdata, d);
    check("rlast", rlast, l);
    check("rid", rid, id);
    check("rresp", rresp, resp);
    @(negedge clk_i);
    rready = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    check("rst_awready", awready, 1);
    check("rst_arready", arready, 1);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_bresp", bresp, 0);
    check("rst_bid", bid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rid", rid, 0);
    check("rst_rresp", rresp, 0);
    // single write / read with latency check
    aw_send(32'h10, 4'd5, 8'd0, 2'b01);
    w_send(32'hDEADBEEF, 4'hF, 1'b1);
    b_recv(2'b00, 4'd5);
    ar_send(32'h10, 4'd3, 8'd0, 2'b01);
    check("lat_rvalid0", rvalid, 0);
    @(negedge clk_i);
    check("lat_rvalid1", rvalid, 1);
    r_recv(32'hDEADBEEF, 1'b1, 4'd3, 2'b00);
    // INCR burst
    aw_send(32'h100, 4'd7, 8'd3, 2'b01);
    for (int i = 0; i < 4; i++) w_send(i + 1, 4'hF, i == 3);
    b_recv(2'b00, 4'd7);
    ar_send(32'h100, 4'd9, 8'd3, 2'b01);
    for (int i = 0; i < 4; i++) r_recv(i + 1, i == 3, 4'd9, 2'b00);
    // byte strobes with FIXED burst
    aw_send(32'h20, 4'd1, 8'd0, 2'b01);
    w_send(32'h11223344, 4'hF, 1'b1);
    b_recv(2'b00, 4'd1);
    aw_send(32'h20, 4'd1, 8'd1, 2'b00);
    w_send(32'h000000AA, 4'h1, 1'b0);
    w_send(32'hBB000000, 4'h8, 1'b1);
    b_recv(2'b00, 4'd1);
    ar_send(32'h20, 4'd2, 8'd0, 2'b01);
    r_recv(32'hBB2233AA, 1'b1, 4'd2, 2'b00);
    // B backpressure
    aw_send(32'h40, 4'd2, 8'd0, 2'b01);
    w_send(32'hCAFE0001, 4'hF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_bvalid", bvalid, 1);
      check("bp_bresp", bresp, 0);
      check("bp_bid", bid, 2);
      check("bp_awready", awready, 0);
      @(negedge clk_i);
    end
    b_recv(2'b00, 4'd2);
    check("bp_awready_after", awready, 1);
    // R backpressure
    aw_send(32'h200, 4'd0, 8'd3, 2'b01);
    for (int i = 0; i < 4; i++) w_send(32'hA0 + i, 4'hF, i == 3);
    b_recv(2'b00, 4'd0);
    ar_send(32'h200, 4'd11, 8'd3, 2'b01);
    for (int i = 0; i < 4; i++) begin
      for (int n = 0; n < 20 && !rvalid; n++) @(negedge clk_i);
      repeat (2) @(negedge clk_i);
      check("rbp_rvalid", rvalid, 1);
      check("rbp_rdata", rdata, 32'hA0 + i);
      check("rbp_rlast", rlast, i == 3);
      r_recv(32'hA0 + i, i == 3, 4'd11, 2'b00);
    end
    // reserved burst type: SLVERR, data written INCR
    aw_send(32'h300, 4'd4, 8'd1, 2'b11);
    w_send(32'h55, 4'hF, 1'b0);
    w_send(32'h66, 4'hF, 1'b1);
    b_recv(2'b10, 4'd4);
    ar_send(32'h300, 4'd4, 8'd1, 2'b01);
    r_recv(32'h55, 1'b0, 4'd4, 2'b00);
    r_recv(32'h66, 1'b1, 4'd4, 2'b00);
    ar_send(32'h300, 4'd6, 8'd0, 2'b10);
    r_recv(32'h55, 1'b1, 4'd6, 2'b10);
    // early wlast
    aw_send(32'h310, 4'd6, 8'd1, 2'b01);
    w_send(32'h1, 4'hF, 1'b1);
    check("early_bvalid", bvalid, 0);
    check("early_wready", wready, 1);
    w_send(32'h2, 4'hF, 1'b0);
    b_recv(2'b10, 4'd6);
    // aliasing beyond capacity
    aw_send(32'h1000, 4'd3, 8'd0, 2'b01);
    w_send(32'h12345678, 4'hF, 1'b1);
    b_recv(2'b00, 4'd3);
    ar_send(32'h0, 4'd3, 8'd0, 2'b01);
    r_recv(32'h12345678, 1'b1, 4'd3, 2'b00);
    // reset mid-burst
    aw_send(32'h400, 4'd8, 8'd3, 2'b01);
    w_send(32'h77, 4'hF, 1'b0);
    w_send(32'h88, 4'hF, 1'b0);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("mid_bvalid", bvalid, 0);
    check("mid_awready", awready, 1);
    check("mid_wready", wready, 0);
    ar_send(32'h400, 4'd1, 8'd1, 2'b01);
    r_recv(32'h77, 1'b0, 4'd1, 2'b00);
    r_recv(32'h88, 1'b1, 4'd1, 2'b00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
